// File: rtl/sha256_job_ctrl.sv
// Host-side sequencer for simplified_sha256. It loads a message from a valid/ready
//   word stream into the shared DPSRAM, starts the core and waits for done. It then
//   reads H0..H7 back and emits them as a valid/ready stream.
// Latency: one DPSRAM write per accepted word. core_start is held for 2 cycles.
//   Each digest word takes RD_A + RD_D + OUT, so at most 1 word per 3 cycles.
// Backpressure: in_valid low stalls LOAD indefinitely. out_ready low holds out_data
//   and out_valid with no extra reads. A new job waits until the FSM is back in IDLE.
// Ports:
//   clk, reset_n                   clock (also the DPSRAM clock); sync active-low reset
//   in_valid/in_ready/in_data      message word stream (32 bit)
//   out_valid/out_ready/out_data   digest word stream H[0..7]; out_last marks H[7]
//   out_last
//   busy, job_cycles               status: not IDLE; cycles from first core_start to done
//   core_start/core_done           start/done handshake with the core
//   core_message_addr/             constant addresses handed to the core
//   core_output_addr
//   core_mem_*                     core memory request, forwarded during START/WAIT
//   mem_*                          muxed DPSRAM port; mem_read_data has 1-cycle latency
module sha256_job_ctrl #(
  parameter int NUM_OF_WORDS = 20,
  parameter int MSG_ADDR     = 0,
  parameter int OUT_ADDR     = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        busy,
  output logic [31:0] job_cycles,
  output logic        core_start,
  output logic [15:0] core_message_addr,
  output logic [15:0] core_output_addr,
  input  logic        core_done,
  input  logic        core_mem_we,
  input  logic [15:0] core_mem_addr,
  input  logic [31:0] core_mem_write_data,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [15:0] MSG_BASE  = 16'(MSG_ADDR);
  localparam logic [15:0] OUT_BASE  = 16'(OUT_ADDR);
  localparam logic [15:0] LAST_WORD = 16'(NUM_OF_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_RD_A, S_RD_D, S_OUT
  } state_t;

  state_t      state;
  logic [15:0] cnt;

  assign core_message_addr = MSG_BASE;
  assign core_output_addr  = OUT_BASE;
  assign busy              = (state != S_IDLE);

  // The core owns the memory port only while it runs. Writes are gated by reset_n
  // so an abort cannot leak a write on the reset edge.
  always_comb begin
    mem_we         = 1'b0;
    mem_addr       = 16'h0000;
    mem_write_data = 32'h0;
    if (state == S_START || state == S_WAIT) begin
      mem_we         = core_mem_we & reset_n;
      mem_addr       = core_mem_addr;
      mem_write_data = core_mem_write_data;
    end else if (state == S_LOAD) begin
      mem_we         = in_valid & in_ready & reset_n;
      mem_addr       = MSG_BASE + cnt;
      mem_write_data = in_data;
    end else if (state == S_RD_A) begin
      mem_addr       = OUT_BASE + cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= 16'h0000;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= 32'h0;
      core_start <= 1'b0;
      job_cycles <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state    <= S_LOAD;
            cnt      <= 16'h0000;
            in_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (cnt == LAST_WORD) begin
              state      <= S_START;
              cnt        <= 16'h0000;
              in_ready   <= 1'b0;
              core_start <= 1'b1;
              job_cycles <= 32'h0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        S_START: begin
          job_cycles <= job_cycles + 32'd1;
          if (cnt == 16'd1) begin
            state      <= S_WAIT;
            cnt        <= 16'h0000;
            core_start <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_WAIT: begin
          // cnt==0 marks the first WAIT cycle. A done left high by the previous
          // job may still be visible here, so it is not sampled yet.
          if (cnt == 16'h0000) begin
            cnt        <= 16'd1;
            job_cycles <= job_cycles + 32'd1;
          end else if (core_done) begin
            state <= S_RD_A;
            cnt   <= 16'h0000;
          end else begin
            job_cycles <= job_cycles + 32'd1;
          end
        end
        S_RD_A: begin
          state <= S_RD_D;
        end
        S_RD_D: begin
          out_data  <= mem_read_data;
          out_valid <= 1'b1;
          out_last  <= (cnt == 16'd7);
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (cnt == 16'd7) begin
              state <= S_IDLE;
            end else begin
              cnt   <= cnt + 16'd1;
              state <= S_RD_A;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
